mini_cpu_param: RTL and testbench
=================================

MINI_CPU_PARAM -- requirements
Module: mini_cpu_param

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set register-file word and result width.
REQ-002 Parameter NREGS, default 16, power of two, SHALL set register count; AW = log2(NREGS).
REQ-003 Parameter IMM_W, default 6, SHALL set immediate magnitude width; IMM_W+1 >= AW.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 opcode  in  3  instruction opcode: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLEAR, 111 DISPLAY.
REQ-007 addr1  in  AW  destination register rd.
REQ-008 addr2  in  AW  source register rs1.
REQ-009 addr3_imm  in  IMM_W+1  shared field: rs2 = top AW bits; immediate = bit IMM_W sign, bits IMM_W-1:0 magnitude (sign-magnitude).
REQ-010 ligar  in  1  power button, active-low (0 = pressed).
REQ-011 enviar  in  1  submit button, active-low.
REQ-012 result  out  DATA_W  last shown value.
REQ-013 ligado  out  1  high in every state except OFF.
REQ-014 estado  out  3  current state code: OFF 000, FETCH 001, DECODE 010, READ 011, CALC 100, SHOW 101, STORE 110.
REQ-015 done  out  1  one-cycle pulse on the cycle the block returns from STORE to FETCH.

Function
REQ-016 Button event SHALL be a release: input sampled 0 then 1 in consecutive cycles (registered press flag, cleared on release).
REQ-017 ligar release SHALL toggle OFF<->FETCH in any state, taking priority over every other transition; leaving a mid-instruction state aborts it with no further register write.
REQ-018 enviar release SHALL be honoured only in FETCH; it latches opcode, addr1, addr2, addr3_imm and moves to DECODE; the enviar press flag SHALL be cleared whenever state != FETCH.
REQ-019 Simultaneous ligar and enviar release in FETCH SHALL go to OFF and discard the instruction.
REQ-020 DECODE, READ, CALC, SHOW SHALL each last exactly one cycle; READ latches R[rs1], R[rs2]; CALC latches the ALU result; SHOW loads result.
REQ-021 STORE SHALL last one cycle (write R[rd]) except CLEAR, which zeroes one register per cycle, index 0 to NREGS-1, NREGS cycles.
REQ-022 Latency: release sampled in FETCH at cycle n -> result updated at n+5 -> done at n+6 (non-CLEAR).
REQ-023 imm SHALL be sign-extended to DATA_W: sign 1 -> -magnitude; -0 equals 0.
REQ-024 LOAD R[rd]=imm; ADD R[rs1]+R[rs2]; ADDI R[rs1]+imm; SUB R[rs1]-R[rs2]; SUBI R[rs1]-imm; MUL low DATA_W bits of R[rs1]*R[rs2]; all wrap modulo 2^DATA_W.
REQ-025 CLEAR SHALL show 0 on result; DISPLAY SHALL show R[rs1] with no register write.
REQ-026 rd == rs1/rs2 SHALL use pre-write operand values.
REQ-027 OFF SHALL retain register contents and result; state ignores enviar.

Reset
REQ-028 rst_n low at posedge clk SHALL force state OFF, all registers 0, result 0, done 0, ligado 0, both press flags 0, latched instruction 0.
REQ-029 Reset SHALL override button events in the same cycle, including mid-CLEAR.

Configuration
REQ-030 Macro MINI_CPU_MUL_EN defined: MUL per REQ-024 with a combinational DATA_W x DATA_W multiplier.
REQ-031 Macro MINI_CPU_MUL_EN undefined: no multiplier instantiated; MUL traverses all states with identical timing, performs no register write, result unchanged.

Verification
REQ-032 Reset, ligar press/release -> estado 001, ligado 1; second ligar press/release -> estado 000, ligado 0.
REQ-033 LOAD rd=3 imm=+5, then LOAD rd=4 imm=-2 (sign 1, mag 2), ADD rd=5 rs1=3 rs2=4 -> result 0x0003, done 6 cycles after enviar release.
REQ-034 R1=0x7FFF, ADDI rd=1 rs1=1 imm=+1 -> result 0x8000; SUBI from 0 imm=+1 -> 0xFFFF.
REQ-035 MUL R2=0x0100 x R3=0x0100 -> result 0x0000 with MINI_CPU_MUL_EN; result unchanged without.
REQ-036 CLEAR -> STORE lasts 16 cycles, then DISPLAY any register -> 0x0000; ligar release during CLEAR -> OFF, untouched upper registers retained.
REQ-037 enviar pressed/released during CALC -> ignored, no second instruction; simultaneous ligar+enviar release in FETCH -> OFF, no write.

Source files
------------

// File: rtl/mini_cpu_param.sv
// rtl/mini_cpu_param.sv - button-driven multi-cycle register-file CPU with sign-magnitude immediates
// Optional feature macro: MINI_CPU_MUL_EN (combinational multiplier for MUL).
module mini_cpu_param #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int IMM_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               opcode,
  input  logic [$clog2(NREGS)-1:0] addr1,
  input  logic [$clog2(NREGS)-1:0] addr2,
  input  logic [IMM_W:0]           addr3_imm,
  input  logic                     ligar,
  input  logic                     enviar,
  output logic [DATA_W-1:0]        result,
  output logic                     ligado,
  output logic [2:0]               estado,
  output logic                     done
);
  localparam int AW = $clog2(NREGS);

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  typedef enum logic [2:0] {
    S_OFF    = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_READ   = 3'b011,
    S_CALC   = 3'b100,
    S_SHOW   = 3'b101,
    S_STORE  = 3'b110
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_ligar_pr;
  logic              r_enviar_pr;
  logic              w_ligar_rel;
  logic              w_enviar_rel;
  logic [2:0]        r_op;
  logic [AW-1:0]     r_rd;
  logic [AW-1:0]     r_rs1;
  logic [IMM_W:0]    r_field;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_result;
  logic [AW-1:0]     r_clr_idx;
  logic              r_done;
  logic              w_clr_last;
  logic              w_store_done;
  logic              w_writes;
  logic [AW-1:0]     w_rs2;
  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu;

  // A release is "was low last cycle, high now"; the press flag is just the registered inverse.
  assign w_ligar_rel  = r_ligar_pr & ligar;
  assign w_enviar_rel = r_enviar_pr & enviar;

  assign w_rs2      = r_field[IMM_W -: AW];
  assign w_mag      = DATA_W'(r_field[IMM_W-1:0]);
  assign w_imm      = r_field[IMM_W] ? -w_mag : w_mag;
  assign w_clr_last = (r_clr_idx == AW'(NREGS - 1));

  assign result = r_result;
  assign done   = r_done;
  assign estado = r_state;
  assign ligado = (r_state != S_OFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_store_done = 1'b0;
    if (w_ligar_rel) begin
      w_next = (r_state == S_OFF) ? S_FETCH : S_OFF;
    end else begin
      case (r_state)
        S_FETCH:  if (w_enviar_rel) w_next = S_DECODE;
        S_DECODE: w_next = S_READ;
        S_READ:   w_next = S_CALC;
        S_CALC:   w_next = S_SHOW;
        S_SHOW:   w_next = S_STORE;
        S_STORE: begin
          if (r_op != OP_CLEAR || w_clr_last) begin
            w_next       = S_FETCH;
            w_store_done = 1'b1;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_alu    = '0;
    w_writes = 1'b0;
    case (r_op)
      OP_LOAD: begin w_alu = w_imm;       w_writes = 1'b1; end
      OP_ADD:  begin w_alu = r_a + r_b;   w_writes = 1'b1; end
      OP_ADDI: begin w_alu = r_a + w_imm; w_writes = 1'b1; end
      OP_SUB:  begin w_alu = r_a - r_b;   w_writes = 1'b1; end
      OP_SUBI: begin w_alu = r_a - w_imm; w_writes = 1'b1; end
`ifdef MINI_CPU_MUL_EN
      OP_MUL:  begin w_alu = r_a * r_b;   w_writes = 1'b1; end
`else
      OP_MUL:  begin w_alu = '0;          w_writes = 1'b0; end
`endif
      default: begin w_alu = '0;          w_writes = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ligar_pr  <= 1'b0;
      r_enviar_pr <= 1'b0;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_field     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_alu       <= '0;
      r_result    <= '0;
      r_clr_idx   <= '0;
      r_done      <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[AW'(i)] <= '0;
    end else begin
      r_ligar_pr  <= ~ligar;
      r_enviar_pr <= (r_state == S_FETCH) & ~enviar;
      r_done      <= w_store_done;
      // A power toggle wins over everything, so nothing else moves on that cycle.
      if (!w_ligar_rel) begin
        case (r_state)
          S_FETCH: begin
            if (w_enviar_rel) begin
              r_op    <= opcode;
              r_rd    <= addr1;
              r_rs1   <= addr2;
              r_field <= addr3_imm;
            end
          end
          S_READ: begin
            r_a <= r_regs[r_rs1];
            r_b <= r_regs[w_rs2];
          end
          S_CALC: r_alu <= w_alu;
          S_SHOW: begin
            case (r_op)
              OP_CLEAR:   r_result <= '0;
              OP_DISPLAY: r_result <= r_a;
`ifdef MINI_CPU_MUL_EN
              OP_MUL:     r_result <= r_alu;
`else
              OP_MUL:     r_result <= r_result;
`endif
              default:    r_result <= r_alu;
            endcase
          end
          S_STORE: begin
            if (r_op == OP_CLEAR) begin
              r_regs[r_clr_idx] <= '0;
              r_clr_idx         <= r_clr_idx + 1'b1;
            end else if (w_writes) begin
              r_regs[r_rd] <= r_alu;
            end
          end
          default: ;
        endcase
      end
      if (r_state != S_STORE) r_clr_idx <= '0;
    end
  end

endmodule

// File: tb/tb_mini_cpu_param.sv
// tb/tb_mini_cpu_param.sv - table-driven directed bench for mini_cpu_param
module tb_mini_cpu_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  opcode = '0;
  logic [3:0]  addr1 = '0;
  logic [3:0]  addr2 = '0;
  logic [6:0]  addr3_imm = '0;
  logic        ligar = 1'b1;
  logic        enviar = 1'b1;
  logic [15:0] result;
  logic        ligado;
  logic [2:0]  estado;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mini_cpu_param dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .addr1(addr1), .addr2(addr2),
    .addr3_imm(addr3_imm), .ligar(ligar), .enviar(enviar), .result(result),
    .ligado(ligado), .estado(estado), .done(done)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [6:0]  f;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [40];
  int   nt = 0;

  localparam logic [2:0] LOAD = 3'd0, ADD = 3'd1, ADDI = 3'd2, SUB = 3'd3;
  localparam logic [2:0] SUBI = 3'd4, MUL = 3'd5, CLEAR = 3'd6, DISP = 3'd7;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                     input logic [6:0] f, input logic [15:0] exp);
    tbl[nt] = '{op, rd, rs1, f, exp, 6};
    nt++;
  endtask

  task automatic toggle_power;
    @(posedge clk); #1 ligar = 1'b0;
    @(posedge clk); #1 ligar = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [6:0] f);
    @(posedge clk); #1;
    opcode = op; addr1 = rd; addr2 = rs1; addr3_imm = f; enviar = 1'b0;
    @(posedge clk); #1;
    enviar = 1'b1;
  endtask

  task automatic run(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                     input logic [6:0] f, input bit disturb, output int lat);
    issue(op, rd, rs1, f);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        opcode = ~op; addr1 = ~rd; addr2 = ~rs1; addr3_imm = ~f;
      end
      if (disturb && k == 2) enviar = 1'b0;
      if (disturb && k == 3) begin
        enviar = 1'b1;
        check("calc_state", {29'd0, estado}, 32'h4);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_chk(input string name, input logic [2:0] op, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [6:0] f,
                         input logic [15:0] exp, input int exp_lat);
    int lat;
    run(op, rd, rs1, f, 1'b0, lat);
    check({name, "_result"}, {16'd0, result}, {16'd0, exp});
    check({name, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int extra;
    logic [15:0] mul_exp;
`ifdef MINI_CPU_MUL_EN
    mul_exp = 16'h0000;
`else
    mul_exp = 16'h0100;
`endif

    put(LOAD, 4'd3,  4'd0,  7'h05, 16'h0005);
    put(LOAD, 4'd4,  4'd0,  7'h42, 16'hFFFE);
    put(ADD,  4'd5,  4'd3,  7'h20, 16'h0003);
    put(DISP, 4'd0,  4'd5,  7'h00, 16'h0003);
    put(SUB,  4'd6,  4'd3,  7'h20, 16'h0007);
    put(ADDI, 4'd12, 4'd3,  7'h40, 16'h0005);
    put(SUBI, 4'd13, 4'd3,  7'h7F, 16'h0044);
    put(LOAD, 4'd7,  4'd0,  7'h20, 16'h0020);
    for (int i = 0; i < 10; i++) put(ADD, 4'd7, 4'd7, 7'h38, 16'h0040 << i);
    put(SUBI, 4'd1,  4'd7,  7'h01, 16'h7FFF);
    put(ADDI, 4'd1,  4'd1,  7'h01, 16'h8000);
    put(SUBI, 4'd9,  4'd0,  7'h01, 16'hFFFF);
    put(ADD,  4'd7,  4'd7,  7'h38, 16'h0000);
    put(LOAD, 4'd10, 4'd0,  7'h20, 16'h0020);
    put(ADD,  4'd10, 4'd10, 7'h50, 16'h0040);
    put(ADD,  4'd10, 4'd10, 7'h50, 16'h0080);
    put(ADD,  4'd10, 4'd10, 7'h50, 16'h0100);
    put(MUL,  4'd10, 4'd10, 7'h50, mul_exp);
    put(DISP, 4'd0,  4'd10, 7'h00, mul_exp);
    put(ADD,  4'd5,  4'd5,  7'h28, 16'h0006);
    put(DISP, 4'd0,  4'd5,  7'h00, 16'h0006);

    repeat (3) @(posedge clk);
    #1;
    check("reset_estado", {29'd0, estado}, 32'h0);
    check("reset_ligado", {31'd0, ligado}, 32'h0);
    check("reset_result", {16'd0, result}, 32'h0);
    check("reset_done", {31'd0, done}, 32'h0);
    rst_n = 1'b1;

    toggle_power;
    check("power_on_estado", {29'd0, estado}, 32'h1);
    check("power_on_ligado", {31'd0, ligado}, 32'h1);
    toggle_power;
    check("power_off_estado", {29'd0, estado}, 32'h0);
    check("power_off_ligado", {31'd0, ligado}, 32'h0);
    @(posedge clk); #1 enviar = 1'b0;
    @(posedge clk); #1 enviar = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("off_ignores_enviar", {29'd0, estado}, 32'h0);
    toggle_power;
    check("power_on_again", {29'd0, estado}, 32'h1);

    for (int i = 0; i < nt; i++) begin
      run(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].f, 1'b0, lat);
      check($sformatf("vec%0d_result", i), {16'd0, result}, {16'd0, tbl[i].exp});
      check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
    end

    // CLEAR aborted by power release while R5 is being zeroed: R0..R4 cleared, R5 up kept.
    issue(CLEAR, 4'd0, 4'd0, 7'h00);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 9) ligar = 1'b0;
      if (k == 10) ligar = 1'b1;
    end
    check("clr_abort_estado", {29'd0, estado}, 32'h0);
    check("clr_abort_done", {31'd0, done}, 32'h0);
    toggle_power;
    run_chk("clr_abort_r3", DISP, 4'd0, 4'd3, 7'h00, 16'h0000, 6);
    run_chk("clr_abort_r4", DISP, 4'd0, 4'd4, 7'h00, 16'h0000, 6);
    run_chk("clr_abort_r5", DISP, 4'd0, 4'd5, 7'h00, 16'h0006, 6);
    run_chk("clr_abort_r6", DISP, 4'd0, 4'd6, 7'h00, 16'h0007, 6);

    run_chk("clear_full", CLEAR, 4'd0, 4'd0, 7'h00, 16'h0000, 21);
    run_chk("clear_r6", DISP, 4'd0, 4'd6, 7'h00, 16'h0000, 6);
    run_chk("clear_r13", DISP, 4'd0, 4'd13, 7'h00, 16'h0000, 6);

    // enviar press/release while the instruction is in CALC must not start another one.
    run(LOAD, 4'd8, 4'd0, 7'h09, 1'b1, lat);
    check("calc_enviar_result", {16'd0, result}, 32'h9);
    check("calc_enviar_latency", lat, 6);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("calc_enviar_no_second", extra, 0);
    check("calc_enviar_estado", {29'd0, estado}, 32'h1);

    @(posedge clk); #1;
    opcode = LOAD; addr1 = 4'd8; addr2 = 4'd0; addr3_imm = 7'h14;
    ligar = 1'b0; enviar = 1'b0;
    @(posedge clk); #1;
    ligar = 1'b1; enviar = 1'b1;
    @(posedge clk); #1;
    check("simul_rel_estado", {29'd0, estado}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("simul_rel_stays_off", {29'd0, estado}, 32'h0);
    toggle_power;
    run_chk("simul_rel_r8", DISP, 4'd0, 4'd8, 7'h00, 16'h0009, 6);

    // Reset in the same cycle as a power release, in the middle of CLEAR.
    issue(CLEAR, 4'd0, 4'd0, 7'h00);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) ligar = 1'b0;
      if (k == 7) begin
        rst_n = 1'b0;
        ligar = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("midclr_rst_estado", {29'd0, estado}, 32'h0);
    check("midclr_rst_ligado", {31'd0, ligado}, 32'h0);
    check("midclr_rst_result", {16'd0, result}, 32'h0);
    check("midclr_rst_done", {31'd0, done}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midclr_rst_no_toggle", {29'd0, estado}, 32'h0);
    toggle_power;
    run_chk("midclr_rst_r8", DISP, 4'd0, 4'd8, 7'h00, 16'h0000, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
